// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-control chain: per-stage metadata
// record and forward-select encoding.
package pipe_pkg;

   localparam int FWD_SEL_W = 4;
   localparam logic [FWD_SEL_W-1:0] FWD_RF = '0;

   // Destination field is sized for the widest register number the chain supports.
   localparam int DEST_W_MAX = 16;

   typedef struct packed {
      logic                  valid;
      logic                  wreg;
      logic                  m2reg;
      logic [DEST_W_MAX-1:0] dest;
   } stage_meta_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// One-operand priority matcher: picks the youngest stage writing the operand and
// flags a load hazard when that stage's load data is not yet available.
module pipe_fwd_match
   import pipe_pkg::*;
#(
   parameter int REG_W      = 5,
   parameter int STAGES     = 3,
   parameter int LOAD_READY = 1
) (
   input  logic [STAGES-1:0]       stage_valid,
   input  logic [STAGES-1:0]       stage_wreg,
   input  logic [STAGES-1:0]       stage_m2reg,
   input  logic [STAGES*REG_W-1:0] stage_dest,
   input  logic [REG_W-1:0]        src,
   input  logic                    use_src,
   output logic [FWD_SEL_W-1:0]    sel,
   output logic                    hazard
);

   // Walk oldest to youngest so the youngest match overwrites older ones; a
   // younger hazard therefore always suppresses an older forwardable match.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sel    = FWD_RF;
      hazard = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (stage_valid[k] && stage_wreg[k] && use_src && (src != '0) &&
             (stage_dest[k*REG_W +: REG_W] == src)) begin
            if (stage_m2reg[k] && (k < LOAD_READY)) begin
               sel    = FWD_RF;
               hazard = 1'b1;
            end else begin
               sel    = FWD_SEL_W'(k + 1);
               hazard = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_chain.sv
// Pipeline-control chain: per-stage instruction metadata, operand forwarding and
// load-use stall generation. Optional counters under `PIPE_HAZARD_PERF_EN`.
module pipe_hazard_chain
   import pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_W      = 5,
   parameter int STAGES     = 3,
   parameter int LOAD_READY = 1
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     id_valid,
   input  logic                     id_wreg,
   input  logic                     id_m2reg,
   input  logic [REG_W-1:0]         id_dest,
   input  logic [REG_W-1:0]         id_rs,
   input  logic [REG_W-1:0]         id_rt,
   input  logic                     id_use_rs,
   input  logic                     id_use_rt,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        rf_rs_data,
   input  logic [DATA_W-1:0]        rf_rt_data,
   input  logic [STAGES*DATA_W-1:0] stage_result,
   output logic                     wpcir,
   output logic [FWD_SEL_W-1:0]     fwd_rs_sel,
   output logic [FWD_SEL_W-1:0]     fwd_rt_sel,
   output logic [DATA_W-1:0]        fwd_rs_data,
   output logic [DATA_W-1:0]        fwd_rt_data,
   output logic [STAGES-1:0]        stage_valid,
   output logic [STAGES-1:0]        stage_wreg,
   output logic [STAGES-1:0]        stage_m2reg,
   output logic [STAGES*REG_W-1:0]  stage_dest
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0]              stall_count,
   output logic [31:0]              flush_count
`endif
);

   stage_meta_t stage_q [STAGES];
   stage_meta_t stage_d [STAGES];
   logic        hazard_rs;
   logic        hazard_rt;
   logic        stall;

   always_comb begin
      stage_valid = '0;
      stage_wreg  = '0;
      stage_m2reg = '0;
      stage_dest  = '0;
      for (int k = 0; k < STAGES; k++) begin
         stage_valid[k]               = stage_q[k].valid;
         stage_wreg[k]                = stage_q[k].wreg;
         stage_m2reg[k]               = stage_q[k].m2reg;
         stage_dest[k*REG_W +: REG_W] = stage_q[k].dest[REG_W-1:0];
      end
   end

   pipe_fwd_match #(
      .REG_W      (REG_W),
      .STAGES     (STAGES),
      .LOAD_READY (LOAD_READY)
   ) u_match_rs (
      .stage_valid (stage_valid),
      .stage_wreg  (stage_wreg),
      .stage_m2reg (stage_m2reg),
      .stage_dest  (stage_dest),
      .src         (id_rs),
      .use_src     (id_use_rs),
      .sel         (fwd_rs_sel),
      .hazard      (hazard_rs)
   );

   pipe_fwd_match #(
      .REG_W      (REG_W),
      .STAGES     (STAGES),
      .LOAD_READY (LOAD_READY)
   ) u_match_rt (
      .stage_valid (stage_valid),
      .stage_wreg  (stage_wreg),
      .stage_m2reg (stage_m2reg),
      .stage_dest  (stage_dest),
      .src         (id_rt),
      .use_src     (id_use_rt),
      .sel         (fwd_rt_sel),
      .hazard      (hazard_rt)
   );

   // A flushed or empty ID slot cannot stall: its bubble goes in regardless.
   assign stall = id_valid && !flush && (hazard_rs || hazard_rt);
   assign wpcir = !stall;

   always_comb begin
      fwd_rs_data = rf_rs_data;
      fwd_rt_data = rf_rt_data;
      for (int k = 0; k < STAGES; k++) begin
         if (fwd_rs_sel == FWD_SEL_W'(k + 1)) fwd_rs_data = stage_result[k*DATA_W +: DATA_W];
         if (fwd_rt_sel == FWD_SEL_W'(k + 1)) fwd_rt_data = stage_result[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      stage_d[0] = '0;
      if (!stall && !flush && id_valid) begin
         stage_d[0].valid = 1'b1;
         stage_d[0].wreg  = id_wreg;
         stage_d[0].m2reg = id_m2reg;
         stage_d[0].dest  = DEST_W_MAX'(id_dest);
      end
      for (int k = 1; k < STAGES; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         // NOTE: this array is control state, not storage; every entry must reset so no stale match survives.
         for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every stage shifts from the pre-edge values.
         for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_count_q, stall_count_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_count_d = stall_count_q + {31'd0, stall};
      flush_count_d = flush_count_q + {31'd0, flush && id_valid};
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_chain.sv
// Self-checking bench for pipe_hazard_chain: directed scenarios plus randomized
// traffic compared against an in-flight instruction model.
module tb_pipe_hazard_chain;

   localparam int DATA_W     = 32;
   localparam int REG_W      = 5;
   localparam int STAGES     = 3;
   localparam int LOAD_READY = 1;

   logic                     clock;
   logic                     resetn;
   logic                     id_valid, id_wreg, id_m2reg;
   logic [REG_W-1:0]         id_dest, id_rs, id_rt;
   logic                     id_use_rs, id_use_rt, flush;
   logic [DATA_W-1:0]        rf_rs_data, rf_rt_data;
   logic [STAGES*DATA_W-1:0] stage_result;
   logic                     wpcir;
   logic [3:0]               fwd_rs_sel, fwd_rt_sel;
   logic [DATA_W-1:0]        fwd_rs_data, fwd_rt_data;
   logic [STAGES-1:0]        stage_valid, stage_wreg, stage_m2reg;
   logic [STAGES*REG_W-1:0]  stage_dest;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0]              stall_count, flush_count;
`endif

   pipe_hazard_chain #(
      .DATA_W     (DATA_W),
      .REG_W      (REG_W),
      .STAGES     (STAGES),
      .LOAD_READY (LOAD_READY)
   ) dut (
      .clock        (clock),
      .resetn       (resetn),
      .id_valid     (id_valid),
      .id_wreg      (id_wreg),
      .id_m2reg     (id_m2reg),
      .id_dest      (id_dest),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .flush        (flush),
      .rf_rs_data   (rf_rs_data),
      .rf_rt_data   (rf_rt_data),
      .stage_result (stage_result),
      .wpcir        (wpcir),
      .fwd_rs_sel   (fwd_rs_sel),
      .fwd_rt_sel   (fwd_rt_sel),
      .fwd_rs_data  (fwd_rs_data),
      .fwd_rt_data  (fwd_rt_data),
      .stage_valid  (stage_valid),
      .stage_wreg   (stage_wreg),
      .stage_m2reg  (stage_m2reg),
      .stage_dest   (stage_dest)
`ifdef PIPE_HAZARD_PERF_EN
      ,
      .stall_count  (stall_count),
      .flush_count  (flush_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model: what each in-flight slot holds (index 0 = youngest).
   bit      m_v [STAGES];
   bit      m_w [STAGES];
   bit      m_m [STAGES];
   int      m_d [STAGES];
   longint  m_stall;
   longint  m_flush;
   bit      exp_wpcir;

   function automatic void model_clear();
      for (int k = 0; k < STAGES; k++) begin
         m_v[k] = 0; m_w[k] = 0; m_m[k] = 0; m_d[k] = 0;
      end
      m_stall = 0;
      m_flush = 0;
   endfunction

   function automatic void model_sel(input int r, input bit use_r, output int sel, output bit haz);
      sel = 0;
      haz = 0;
      for (int k = 0; k < STAGES; k++) begin
         if (m_v[k] && m_w[k] && m_d[k] == r && r != 0 && use_r) begin
            if (m_m[k] && k < LOAD_READY) haz = 1;
            else sel = k + 1;
            break;
         end
      end
   endfunction

   task automatic set_id(input bit v, input bit w, input bit m, input int d,
                         input int rs, input int rt, input bit urs, input bit urt, input bit fl);
      id_valid = v; id_wreg = w; id_m2reg = m; id_dest = REG_W'(d);
      id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_use_rs = urs; id_use_rt = urt; flush = fl;
   endtask

   task automatic settle();
      int s_rs, s_rt;
      bit h_rs, h_rt;
      logic [DATA_W-1:0]       e_rs, e_rt;
      logic [STAGES-1:0]       e_v, e_w, e_m;
      logic [STAGES*REG_W-1:0] e_d;
      #1;
      model_sel(int'(id_rs), id_use_rs, s_rs, h_rs);
      model_sel(int'(id_rt), id_use_rt, s_rt, h_rt);
      exp_wpcir = !(id_valid && !flush && (h_rs || h_rt));
      e_rs = (s_rs != 0) ? stage_result[(s_rs-1)*DATA_W +: DATA_W] : rf_rs_data;
      e_rt = (s_rt != 0) ? stage_result[(s_rt-1)*DATA_W +: DATA_W] : rf_rt_data;
      for (int k = 0; k < STAGES; k++) begin
         e_v[k] = m_v[k]; e_w[k] = m_w[k]; e_m[k] = m_m[k];
         e_d[k*REG_W +: REG_W] = REG_W'(m_d[k]);
      end
      check("wpcir",       64'(wpcir),       64'(exp_wpcir));
      check("fwd_rs_sel",  64'(fwd_rs_sel),  64'(s_rs));
      check("fwd_rt_sel",  64'(fwd_rt_sel),  64'(s_rt));
      check("fwd_rs_data", 64'(fwd_rs_data), 64'(e_rs));
      check("fwd_rt_data", 64'(fwd_rt_data), 64'(e_rt));
      check("stage_valid", 64'(stage_valid), 64'(e_v));
      check("stage_wreg",  64'(stage_wreg),  64'(e_w));
      check("stage_m2reg", 64'(stage_m2reg), 64'(e_m));
      check("stage_dest",  64'(stage_dest),  64'(e_d));
`ifdef PIPE_HAZARD_PERF_EN
      check("stall_count", 64'(stall_count), 64'(m_stall[31:0]));
      check("flush_count", 64'(flush_count), 64'(m_flush[31:0]));
`endif
   endtask

   task automatic advance();
      bit bubble;
      @(posedge clock);
      bubble = !exp_wpcir || flush || !id_valid;
      if (!exp_wpcir) m_stall++;
      if (flush && id_valid) m_flush++;
      for (int k = STAGES - 1; k >= 1; k--) begin
         m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_m[k] = m_m[k-1]; m_d[k] = m_d[k-1];
      end
      m_v[0] = bubble ? 0 : 1;
      m_w[0] = bubble ? 0 : id_wreg;
      m_m[0] = bubble ? 0 : id_m2reg;
      m_d[0] = bubble ? 0 : int'(id_dest);
      @(negedge clock);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      check("rst_stage_valid", 64'(stage_valid), 64'd0);
      check("rst_wpcir",       64'(wpcir),       64'd1);
      check("rst_fwd_rs_sel",  64'(fwd_rs_sel),  64'd0);
      check("rst_fwd_rs_data", 64'(fwd_rs_data), 64'(rf_rs_data));
`ifdef PIPE_HAZARD_PERF_EN
      check("rst_stall_count", 64'(stall_count), 64'd0);
      check("rst_flush_count", 64'(flush_count), 64'd0);
`endif
      model_clear();
      @(negedge clock);
      resetn = 1'b1;
   endtask

   initial begin
      resetn       = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rf_rs_data   = 32'hAAAA_0000;
      rf_rt_data   = 32'hBBBB_0000;
      stage_result = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      model_clear();

      // Reset state
      #1;
      check("reset_fwd_rs_data", 64'(fwd_rs_data), 64'h0000_0000_AAAA_0000);
      do_reset();

      // ALU back-to-back
      set_id(1, 1, 0, 8, 0, 0, 0, 0, 0); settle(); advance();
      stage_result[0 +: DATA_W] = 32'h0000_1234;
      set_id(1, 1, 0, 3, 8, 0, 1, 0, 0); settle();
      check("alu_rs_sel",  64'(fwd_rs_sel),  64'd1);
      check("alu_rs_data", 64'(fwd_rs_data), 64'h1234);
      check("alu_wpcir",   64'(wpcir),       64'd1);
      advance();

      // Load-use: one-cycle stall, then forward from stage 1
      set_id(1, 1, 1, 9, 0, 0, 0, 0, 0); settle(); advance();
      set_id(1, 1, 0, 4, 0, 9, 0, 1, 0); settle();
      check("ld_stall_wpcir", 64'(wpcir), 64'd0);
      advance();
      settle();
      check("ld_next_valid0", 64'(stage_valid[0]), 64'd0);
      check("ld_next_rt_sel", 64'(fwd_rt_sel),     64'd2);
      check("ld_next_wpcir",  64'(wpcir),          64'd1);
      advance();

      // Priority: youngest writer wins
      set_id(1, 1, 0, 5, 0, 0, 0, 0, 0); settle(); advance();
      set_id(1, 1, 0, 5, 0, 0, 0, 0, 0); settle(); advance();
      set_id(1, 0, 0, 0, 5, 0, 1, 0, 0); settle();
      check("prio_rs_sel", 64'(fwd_rs_sel), 64'd1);
      advance();

      // Register 0 never forwards
      for (int i = 0; i < STAGES; i++) begin
         set_id(1, 1, i[0], 0, 0, 0, 0, 0, 0); settle(); advance();
      end
      set_id(1, 0, 0, 0, 0, 0, 1, 1, 0); settle();
      check("r0_rs_sel", 64'(fwd_rs_sel), 64'd0);
      check("r0_wpcir",  64'(wpcir),      64'd1);
      advance();

      // Flush with pending load hazard
      set_id(1, 1, 1, 9, 0, 0, 0, 0, 0); settle(); advance();
      set_id(1, 1, 0, 4, 0, 9, 0, 1, 1); settle();
      check("flush_wpcir", 64'(wpcir), 64'd1);
      advance();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
      check("flush_valid0", 64'(stage_valid[0]), 64'd0);
      advance();

      // Reset asserted mid-stall
      set_id(1, 1, 1, 9, 0, 0, 0, 0, 0); settle(); advance();
      set_id(1, 1, 0, 4, 9, 0, 1, 0, 0); settle();
      check("midrst_pre_wpcir", 64'(wpcir), 64'd0);
      do_reset();
      settle();

      // Counters: three stalls, two flushes
      for (int i = 0; i < 3; i++) begin
         set_id(1, 1, 1, 9, 0, 0, 0, 0, 0); settle(); advance();
         set_id(1, 1, 0, 4, 0, 9, 0, 1, 0); settle(); advance();
         settle(); advance();
      end
      for (int i = 0; i < 2; i++) begin
         set_id(1, 1, 0, 6, 0, 0, 0, 0, 1); settle(); advance();
      end
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
`ifdef PIPE_HAZARD_PERF_EN
      check("perf_stall_3", 64'(stall_count), 64'd3);
      check("perf_flush_2", 64'(flush_count), 64'd2);
`endif
      do_reset();

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
         rf_rs_data = $urandom;
         rf_rt_data = $urandom;
         for (int k = 0; k < STAGES; k++) stage_result[k*DATA_W +: DATA_W] = $urandom;
         settle();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_chain.md
# pipe_hazard_chain

Parametrised pipeline-control chain for the pipelined MIPS core. It tracks the control metadata (valid, wreg, m2reg, destination register) of every in-flight instruction from the ID/EXE register through the last write-back stage. It also resolves operand forwarding and load-use stalls for the instruction in ID. It replaces hand-wired per-stage bypass/stall logic, and generalises to any stage count and load-ready depth.

## Interface
- DATA_W, 32, datapath/result width
- REG_W, 5, register-number width
- STAGES, 3, tracked stages after ID (index 0 = EXE, 1 = MEM, STAGES-1 = WB); legal range 2..8
- LOAD_READY, 1, first stage index at which a load's data is valid on stage_result; 1 ≤ LOAD_READY < STAGES
- clock  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_wreg, id_m2reg  in  1 each  ID instruction writes a register / is a load
- id_dest  in  REG_W  ID destination register
- id_rs, id_rt  in  REG_W  ID source registers
- id_use_rs, id_use_rt  in  1 each  operand actually read
- flush  in  1  squash the ID instruction this cycle
- rf_rs_data, rf_rt_data  in  DATA_W  register-file read data
- stage_result  in  STAGES*DATA_W  per-stage result; slice k = stage k
- wpcir  out  1  active-low stall; 0 holds PC and IF/ID
- fwd_rs_sel, fwd_rt_sel  out  4  0 = register file, k+1 = stage k
- fwd_rs_data, fwd_rt_data  out  DATA_W  selected operand values
- stage_valid, stage_wreg, stage_m2reg  out  STAGES each  per-stage metadata, bit k = stage k
- stage_dest  out  STAGES*REG_W  per-stage destination registers

## Operation
- Per-stage metadata register {valid, wreg, m2reg, dest}. On every clock, stage k+1 ← stage k for k ≥ 1, and stage 1 ← stage 0. Downstream stages never stall.
- Stage 0 loads a bubble (valid=0; wreg, m2reg, dest = 0) when any of the following is true: wpcir=0, flush=1, or id_valid=0. Otherwise it loads the ID metadata.
- A stage k matches operand r when all of the following hold: valid, wreg, dest == r, r ≠ 0, and use_r is asserted.
- Forward select is the youngest (lowest k) matching stage; with no match, the select is 0 and the data comes from the register file.
- Load hazard: the youngest matching stage k has m2reg=1 and k < LOAD_READY. In that case wpcir=0 and the select is forced to 0.
- An older match is never used when a younger match is a hazard.
- wpcir = 0 only when id_valid=1, flush=0, and a load hazard exists on rs or rt.
- fwd_*_data = stage_result slice (sel-1) when sel ≠ 0; otherwise rf_*_data.
- Register 0 never forwards and never stalls.

## Timing
- wpcir, the selects and the data outputs are combinational from the current stage state and ID inputs, so they are valid in the same cycle.
- Load-use stall lasts LOAD_READY − k cycles. With the defaults, a load in stage 0 stalls for exactly 1 cycle. The next cycle forwards from stage 1.
- Reset (asynchronous, immediate) clears all stage metadata to 0. As a result, wpcir=1, all selects are 0, and fwd data equals rf data.
- Reset asserted mid-stall: the stall is cancelled on reset, and no metadata survives.
- flush and hazard in the same cycle: wpcir=1 and stage 0 receives a bubble.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds outputs stall_count and flush_count (32 bits each, cleared by reset).
  - stall_count increments on each cycle with wpcir=0.
  - flush_count increments on each cycle with flush=1 and id_valid=1.
  - Both counters wrap at 2^32−1 → 0.
- PIPE_HAZARD_PERF_EN not defined: no counters and no ports; behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - the stage-metadata struct typedef;
  - FWD_RF = 0;
  - the select width constant (4).
- Sub-module pipe_fwd_match: one-operand priority matcher over all stages, returning the select and a hazard flag. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset: hold resetn=0 → stage_valid=0, wpcir=1, fwd_rs_sel=0, and fwd_rs_data equals rf_rs_data=0xAAAA_0000.
- ALU back-to-back: issue a writer of r8, then a reader of rs=8, with stage_result[0]=0x1234 → fwd_rs_sel=1, fwd_rs_data=0x1234, wpcir=1.
- Load-use: issue a load to r9, then a reader of rt=9 → wpcir=0 for one cycle. On the next cycle: stage_valid[0]=0, fwd_rt_sel=2, wpcir=1.
- Priority: stage 0 and stage 1 both write r5, reader uses rs=5 → fwd_rs_sel=1. With dest=0 in every stage → sel=0.
- flush with a pending load hazard → wpcir=1; stage_valid[0]=0 on the next cycle.
- PIPE_HAZARD_PERF_EN: 3 stall cycles and 2 flushes → stall_count=3, flush_count=2. After a reset pulse, both read 0.
